// File: rtl/simon_ctrl_if.sv
// Control bundle between the top-level start/eoc handshake and the Simon round controller.
// The master drives one request per start pulse. The controller samples start only in
// IDLE or DONE, so there is no ready signal. eoc stays high in DONE until a new
// operation is accepted or the run is aborted.
interface simon_ctrl_if #(
    parameter int MAX_ROUNDS = 72,
    parameter int CNT_W      = $clog2(MAX_ROUNDS + 1)
);
    logic             start;
    logic             abort;
    logic             decrypt;
    logic [CNT_W-1:0] n_rounds;
    logic             load;
    logic             compute;
    logic [CNT_W-1:0] round_idx;
    logic             last_round;
    logic             busy;
    logic             eoc;
    logic             err;

    modport master (
        output start, abort, decrypt, n_rounds,
        input  load, compute, round_idx, last_round, busy, eoc, err
    );

    modport slave (
        input  start, abort, decrypt, n_rounds,
        output load, compute, round_idx, last_round, busy, eoc, err
    );
endinterface

// File: rtl/simon_ctrl_gen.sv
// Round controller for Simon. It supports a run-time round count, both directions and abort,
// and flags illegal round counts.
module simon_ctrl_gen #(
    parameter int MAX_ROUNDS = 72,
    parameter int CNT_W      = $clog2(MAX_ROUNDS + 1)
) (
    input  logic        clk,
    input  logic        nrst,
    simon_ctrl_if.slave bus,
    output logic [1:0]  state_dbg
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] MAX_N = CNT_W'(MAX_ROUNDS);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    state_t           state, state_next;
    logic [CNT_W-1:0] n_lat, n_next;
    logic [CNT_W-1:0] idx, idx_next;
    logic             dec_lat, dec_next;
    logic             err_r, err_next;
    logic             req_ok;
    logic             at_last;
    logic             accept;
    logic             clear;

    assign req_ok  = (bus.n_rounds != '0) && (bus.n_rounds <= MAX_N);
    assign at_last = dec_lat ? (idx == '0) : (idx == n_lat - ONE);

    always_comb begin
        state_next = state;
        n_next     = n_lat;
        dec_next   = dec_lat;
        idx_next   = idx;
        err_next   = 1'b0;
        accept     = 1'b0;
        clear      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept   = req_ok;
                    err_next = !req_ok;
                end
            end
            LOAD: begin
                if (bus.abort) clear = 1'b1;
                else           state_next = RUN;
            end
            RUN: begin
                if (bus.abort)   clear = 1'b1;
                else if (at_last) state_next = DONE;
                else if (dec_lat) idx_next = idx - ONE;
                else              idx_next = idx + ONE;
            end
            DONE: begin
                if (bus.abort) begin
                    clear = 1'b1;
                end else if (bus.start) begin
                    accept   = req_ok;
                    err_next = !req_ok;
                end
            end
            default: clear = 1'b1;
        endcase
        // The round index is preset here, so LOAD already shows the first round.
        if (accept) begin
            state_next = LOAD;
            n_next     = bus.n_rounds;
            dec_next   = bus.decrypt;
            idx_next   = bus.decrypt ? (bus.n_rounds - ONE) : '0;
        end
        if (clear) begin
            state_next = IDLE;
            n_next     = '0;
            dec_next   = 1'b0;
            idx_next   = '0;
            err_next   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state   <= IDLE;
            n_lat   <= '0;
            dec_lat <= 1'b0;
            idx     <= '0;
            err_r   <= 1'b0;
        end else begin
            state   <= state_next;
            n_lat   <= n_next;
            dec_lat <= dec_next;
            idx     <= idx_next;
            err_r   <= err_next;
        end
    end

    assign bus.load       = (state == LOAD);
    assign bus.compute    = (state == RUN);
    assign bus.busy       = (state == LOAD) || (state == RUN);
    assign bus.eoc        = (state == DONE);
    assign bus.last_round = (state == RUN) && at_last;
    assign bus.round_idx  = idx;
    assign bus.err        = err_r;
    assign state_dbg      = state;
endmodule

// File: tb/tb_simon_ctrl_gen.sv
// Bench for simon_ctrl_gen. Directed and random operations are checked against a model that
// predicts the round-index sequence and the output phases of each operation.
module tb_simon_ctrl_gen;
    localparam int MAX_ROUNDS = 72;
    localparam int CNT_W      = $clog2(MAX_ROUNDS + 1);

    logic       clk = 1'b0;
    logic       nrst;
    logic [1:0] state_dbg;

    simon_ctrl_if #(.MAX_ROUNDS(MAX_ROUNDS), .CNT_W(CNT_W)) bus ();

    simon_ctrl_gen #(.MAX_ROUNDS(MAX_ROUNDS), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .bus       (bus.slave),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model of the resting outputs: eoc and the held index while idle or done.
    logic             m_eoc;
    logic [CNT_W-1:0] m_idx;
    logic [CNT_W-1:0] exp_q[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic l, input logic c, input logic lr,
                              input logic b, input logic e, input logic er,
                              input logic [CNT_W-1:0] idx);
        logic [5:0]       obs_f, exp_f;
        logic [CNT_W-1:0] obs_i;
        obs_f = {bus.load, bus.compute, bus.last_round, bus.busy, bus.eoc, bus.err};
        obs_i = bus.round_idx;
        exp_f = {l, c, lr, b, e, er};
        n_cmp++;
        assert (obs_f === exp_f && obs_i === idx) else begin
            n_bad++;
            $display("FAIL %s: observed ld/cp/lr/bz/eoc/err=%b idx=%0d, expected %b idx=%0d",
                     tag, obs_f, obs_i, exp_f, idx);
            $error("check %s", tag);
        end
    endtask

    task automatic rest_check(input string tag);
        expect_out(tag, 1'b0, 1'b0, 1'b0, 1'b0, m_eoc, 1'b0, m_idx);
    endtask

    task automatic bad_req(input string tag, input int n);
        bus.start    = 1'b1;
        bus.n_rounds = CNT_W'(n);
        bus.decrypt  = 1'($urandom);
        tick();
        bus.start = 1'b0;
        expect_out({tag, " err"}, 1'b0, 1'b0, 1'b0, 1'b0, m_eoc, 1'b1, m_idx);
        tick();
        rest_check({tag, " after"});
    endtask

    // cut_at >= 0 aborts (or resets) on the edge that would enter round cut_at.
    task automatic run_op(input string tag, input logic dec, input int n, input int cut_at,
                          input bit by_reset, input int hold);
        logic [CNT_W-1:0] e_idx;
        exp_q.delete();
        for (int k = 0; k < n; k++) exp_q.push_back(CNT_W'(dec ? n - 1 - k : k));
        bus.start    = 1'b1;
        bus.decrypt  = dec;
        bus.n_rounds = CNT_W'(n);
        tick();
        bus.start    = 1'b0;
        bus.decrypt  = 1'($urandom);
        bus.n_rounds = CNT_W'($urandom);
        expect_out({tag, " load"}, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, exp_q[0]);
        for (int i = 0; i < n; i++) begin
            if (i == cut_at) begin
                bus.start    = 1'b1;
                bus.n_rounds = CNT_W'($urandom_range(1, MAX_ROUNDS));
                if (by_reset) nrst = 1'b0;
                else          bus.abort = 1'b1;
                tick();
                m_eoc = 1'b0;
                m_idx = '0;
                rest_check({tag, by_reset ? " reset" : " abort"});
                nrst      = 1'b1;
                bus.abort = 1'b0;
                if (!by_reset) bus.start = 1'b0;
                return;
            end
            bus.start    = 1'($urandom_range(0, 1));
            bus.n_rounds = CNT_W'($urandom_range(0, 127));
            tick();
            e_idx = exp_q.pop_front();
            expect_out({tag, " run"}, 1'b0, 1'b1, (i == n - 1), 1'b1, 1'b0, 1'b0, e_idx);
        end
        bus.start = 1'($urandom_range(0, 1));
        tick();
        bus.start = 1'b0;
        m_eoc = 1'b1;
        m_idx = CNT_W'(dec ? 0 : n - 1);
        rest_check({tag, " done"});
        for (int h = 1; h < hold; h++) begin
            tick();
            rest_check({tag, " hold"});
        end
    endtask

    initial begin
        int n;
        int cut;
        nrst         = 1'b0;
        bus.start    = 1'b0;
        bus.abort    = 1'b0;
        bus.decrypt  = 1'b0;
        bus.n_rounds = '0;
        m_eoc        = 1'b0;
        m_idx        = '0;
        tick();
        tick();
        rest_check("reset");
        nrst = 1'b1;
        tick();
        rest_check("idle");

        run_op("enc32", 1'b0, 32, -1, 1'b0, 11);
        run_op("dec44", 1'b1, 44, -1, 1'b0, 3);
        bad_req("done_bad0", 0);

        bus.abort = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.abort = 1'b0;
        bus.start = 1'b0;
        m_eoc = 1'b0;
        m_idx = '0;
        rest_check("abort_done");
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        rest_check("abort_idle");

        bad_req("bad0", 0);
        bad_req("bad73", MAX_ROUNDS + 1);
        bad_req("bad127", 127);
        run_op("enc72", 1'b0, MAX_ROUNDS, -1, 1'b0, 2);

        run_op("abort10", 1'b0, 36, 10, 1'b0, 1);
        run_op("post_abort", 1'b0, 5, -1, 1'b0, 2);
        run_op("enc1", 1'b0, 1, -1, 1'b0, 2);
        run_op("dec1", 1'b1, 1, -1, 1'b0, 2);
        run_op("dec72", 1'b1, MAX_ROUNDS, -1, 1'b0, 1);

        run_op("rst_mid", 1'b0, 20, 7, 1'b1, 1);
        run_op("post_rst", 1'b1, 9, -1, 1'b0, 2);

        for (int r = 0; r < 10; r++) begin
            n   = $urandom_range(1, MAX_ROUNDS);
            cut = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1;
            run_op("rand", 1'($urandom), n, cut, 1'($urandom), 2);
            if ($urandom_range(0, 2) == 0) bad_req("rand_bad", $urandom_range(MAX_ROUNDS + 1, 127));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/simon_ctrl_gen.md
Name: simon_ctrl_gen

Overview:
Generalised round controller for the Simon block-cipher datapath. It supports a run-time round count up to MAX_ROUNDS, so all Simon block/key variants can share one controller. It also supports encrypt/decrypt direction, a round index for key-schedule/z-sequence addressing, abort, and an error flag for illegal round counts. It sits between the top-level start/eoc handshake and the Simon round datapath plus key schedule.

Parameters:
MAX_ROUNDS, 72, largest legal round count (Simon 128/256).
CNT_W, $clog2(MAX_ROUNDS+1), width of the round-count and index fields.

Ports:
clk  input  1  clock, rising edge
nrst  input  1  synchronous reset, active-low
start  input  1  request a new operation; sampled in IDLE or DONE only
abort  input  1  cancel current operation
decrypt  input  1  0 = encrypt, 1 = decrypt; latched with start
n_rounds  input  CNT_W  rounds for this operation; latched with start
load  output  1  one-cycle pulse: datapath captures plaintext/key
compute  output  1  high during every round cycle
round_idx  output  CNT_W  current round index
last_round  output  1  high during the final compute cycle
busy  output  1  high in LOAD or RUN
eoc  output  1  end of computation; held high in DONE
err  output  1  one-cycle pulse: start rejected

Behaviour:
- Synchronous active-low reset (nrst low at a clk edge): state=IDLE. All outputs are 0, round_idx=0, latched mode and count cleared. Reset mid-operation gives the same result; eoc is never asserted for an aborted run.
- States are IDLE, LOAD, RUN and DONE. Outputs are registered or decoded from state only, with no combinational path from inputs.
- IDLE:
  - start=1 with 1 <= n_rounds <= MAX_ROUNDS: latch n_rounds and decrypt, then go to LOAD.
  - start=1 with n_rounds=0 or n_rounds>MAX_ROUNDS: pulse err for one cycle and stay in IDLE.
- LOAD: lasts one cycle with load=1 and busy=1, then goes to RUN.
  - Encrypt: preset round_idx=0.
  - Decrypt: preset round_idx=n-1.
- RUN:
  - compute=1 and busy=1 every cycle; exactly n cycles are spent in RUN.
  - round_idx steps +1 per cycle for encrypt (0..n-1) and -1 per cycle for decrypt (n-1..0).
  - last_round=1 when round_idx=n-1 (encrypt) or round_idx=0 (decrypt).
  - After the last-round cycle, go to DONE.
- DONE:
  - eoc=1, compute=0, busy=0. round_idx holds its final value.
  - Stays in DONE until start=1. A valid start goes directly to LOAD and eoc drops in that same cycle. An invalid start pulses err and stays in DONE with eoc still high.
- Latency: start sampled at edge t gives load high in cycle t+1, compute high in cycles t+2..t+n+1, and eoc high from cycle t+n+2. The n=1 case has compute and last_round high together in one cycle.
- start while busy is ignored: no err, and the latched values are unchanged.
- abort=1 in LOAD, RUN or DONE: go to IDLE at the next edge with all outputs cleared.
  - abort has priority over start and over the round counter.
  - abort in IDLE has no effect, and err is not raised.
- Inputs decrypt and n_rounds may change freely after being latched.
- The counter never wraps: round_idx never leaves the range 0..n-1.

Test Plan:
1. Encrypt, n_rounds=32, start one cycle -> load in cycle 1; compute in cycles 2..33 with round_idx 0..31; last_round with idx=31; eoc from cycle 34 and held for 10 idle cycles.
2. Decrypt, n_rounds=44 -> round_idx counts 43..0; last_round at idx=0; exactly 44 compute cycles; then eoc.
3. n_rounds=0, then n_rounds=MAX_ROUNDS+1 -> err pulses once per request, state stays IDLE, no load; then n_rounds=MAX_ROUNDS=72 -> 72 compute cycles.
4. Abort at round 10 of 36, with start also high -> IDLE at next edge; all outputs 0; no eoc; a new start then runs normally from idx 0.
5. In DONE, start n_rounds=1 -> eoc drops same cycle; load; one cycle with compute and last_round, idx=0; eoc again.
6. nrst low for one cycle mid-RUN, with start held high through the reset -> all outputs 0 after the edge; the first start sampled after reset releases begins a clean run.
